// File: rtl/sieve_stride_counter.sv
// rtl/sieve_stride_counter.sv - multi-channel base/stride counter emitting Step pulses per value.
// Define SIEVE_STRIDE_WRAPS_EN to add per-channel saturating rollover counters on Wraps.
module sieve_stride_counter #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 4,
    parameter int INC_W       = 10,
    parameter int COUNT_LIMIT = 1000000,
    parameter int ROLLOVER    = 0,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      Clear,
    input  logic                      Load_valid,
    output logic                      Load_ready,
    input  logic [CH_W-1:0]           Load_ch,
    input  logic [WIDTH-1:0]          Load_base,
    input  logic [INC_W-1:0]          Load_stride,
    input  logic [CHANNELS-1:0]       En,
    output logic [WIDTH*CHANNELS-1:0] Count,
    output logic [CHANNELS-1:0]       Step,
    output logic [CHANNELS-1:0]       TC,
    output logic                      All_done
`ifdef SIEVE_STRIDE_WRAPS_EN
    ,
    output logic [8*CHANNELS-1:0]     Wraps
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    // Sums are formed one bit wider than Count so an overshoot is never hidden by wrap-around.
    localparam logic [WIDTH:0] LIMIT_M1 = (WIDTH+1)'(COUNT_LIMIT - 1);

    state_t             state_q  [CHANNELS];
    state_t             state_d  [CHANNELS];
    logic [WIDTH-1:0]   count_q  [CHANNELS];
    logic [WIDTH-1:0]   count_d  [CHANNELS];
    logic [WIDTH-1:0]   base_q   [CHANNELS];
    logic [WIDTH-1:0]   base_d   [CHANNELS];
    logic [INC_W-1:0]   stride_q [CHANNELS];
    logic [INC_W-1:0]   stride_d [CHANNELS];
    logic [CHANNELS-1:0] step_q;
    logic [CHANNELS-1:0] step_d;
`ifdef SIEVE_STRIDE_WRAPS_EN
    logic [7:0]         wraps_q  [CHANNELS];
    logic [7:0]         wraps_d  [CHANNELS];
`endif

    logic           load_fire;
    logic           load_bad;
    logic [WIDTH:0] next_val;

    always_comb begin
        Load_ready = 1'b0;
        if (!Clear && (32'(Load_ch) < CHANNELS)) begin
            Load_ready = (state_q[Load_ch] != ST_RUN);
        end
    end

    assign load_fire = Load_valid && Load_ready;
    assign load_bad  = ({1'b0, Load_base} > LIMIT_M1) || (Load_stride == '0);

    always_comb begin
        step_d   = '0;
        next_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            count_d[i]  = count_q[i];
            base_d[i]   = base_q[i];
            stride_d[i] = stride_q[i];
`ifdef SIEVE_STRIDE_WRAPS_EN
            wraps_d[i]  = wraps_q[i];
`endif
            if (Clear) begin
                state_d[i]  = ST_IDLE;
                count_d[i]  = '0;
                base_d[i]   = '0;
                stride_d[i] = '0;
`ifdef SIEVE_STRIDE_WRAPS_EN
                wraps_d[i]  = '0;
`endif
            end else if (load_fire && (Load_ch == CH_W'(i))) begin
                count_d[i] = Load_base;
`ifdef SIEVE_STRIDE_WRAPS_EN
                wraps_d[i] = '0;
`endif
                if (load_bad) begin
                    state_d[i] = ST_DONE;
                end else begin
                    state_d[i]  = ST_RUN;
                    base_d[i]   = Load_base;
                    stride_d[i] = Load_stride;
                    step_d[i]   = 1'b1;
                end
            end else if ((state_q[i] == ST_RUN) && En[i]) begin
                next_val = {1'b0, count_q[i]} + (WIDTH+1)'(stride_q[i]);
                if (next_val <= LIMIT_M1) begin
                    count_d[i] = next_val[WIDTH-1:0];
                    step_d[i]  = 1'b1;
                end else if (ROLLOVER == 0) begin
                    state_d[i] = ST_DONE;
                end else begin
                    count_d[i] = base_q[i];
                    step_d[i]  = 1'b1;
`ifdef SIEVE_STRIDE_WRAPS_EN
                    if (wraps_q[i] != 8'hff) begin
                        wraps_d[i] = wraps_q[i] + 8'd1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            step_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_IDLE;
                count_q[i]  <= '0;
                base_q[i]   <= '0;
                stride_q[i] <= '0;
`ifdef SIEVE_STRIDE_WRAPS_EN
                wraps_q[i]  <= '0;
`endif
            end
        end else begin
            step_q <= step_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                base_q[i]   <= base_d[i];
                stride_q[i] <= stride_d[i];
`ifdef SIEVE_STRIDE_WRAPS_EN
                wraps_q[i]  <= wraps_d[i];
`endif
            end
        end
    end

    always_comb begin
        Count    = '0;
        TC       = '0;
        All_done = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            Count[i*WIDTH +: WIDTH] = count_q[i];
            TC[i] = (state_q[i] == ST_DONE);
            if (state_q[i] == ST_RUN) begin
                All_done = 1'b0;
            end
        end
    end

    assign Step = step_q;

`ifdef SIEVE_STRIDE_WRAPS_EN
    always_comb begin
        Wraps = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            Wraps[i*8 +: 8] = wraps_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_sieve_stride_counter.sv
// tb/tb_sieve_stride_counter.sv - randomized bench for sieve_stride_counter against a behavioural model.
// Two instances share stimulus: a stop-at-limit one (LIMIT=256) and a rollover one (LIMIT=10).
module tb_sieve_stride_counter;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Clear = 1'b0;
    logic        Load_valid = 1'b0;
    logic [1:0]  Load_ch = '0;
    logic [7:0]  Load_base = '0;
    logic [5:0]  Load_stride = '0;
    logic [3:0]  En = '0;

    logic        rdy_a, rdy_b, ad_a, ad_b;
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  step_a, step_b, tc_a, tc_b;
`ifdef SIEVE_STRIDE_WRAPS_EN
    logic [31:0] wr_a, wr_b;
`endif

    int n_total = 0;
    int n_bad   = 0;

    int lim [2] = '{256, 10};
    int rol [2] = '{0, 1};
    // Model state per instance/channel: 0 idle, 1 run, 2 done.
    int m_st   [2][4];
    int m_cnt  [2][4];
    int m_base [2][4];
    int m_str  [2][4];
    int m_wr   [2][4];
    int m_step [2][4];

    always #5 Clock = ~Clock;

    sieve_stride_counter #(.WIDTH(8), .CHANNELS(4), .INC_W(6), .COUNT_LIMIT(256), .ROLLOVER(0)) u_a (
        .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear), .Load_valid(Load_valid), .Load_ready(rdy_a),
        .Load_ch(Load_ch), .Load_base(Load_base), .Load_stride(Load_stride), .En(En),
        .Count(cnt_a), .Step(step_a), .TC(tc_a), .All_done(ad_a)
`ifdef SIEVE_STRIDE_WRAPS_EN
        , .Wraps(wr_a)
`endif
    );

    sieve_stride_counter #(.WIDTH(8), .CHANNELS(4), .INC_W(6), .COUNT_LIMIT(10), .ROLLOVER(1)) u_b (
        .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear), .Load_valid(Load_valid), .Load_ready(rdy_b),
        .Load_ch(Load_ch), .Load_base(Load_base), .Load_stride(Load_stride), .En(En),
        .Count(cnt_b), .Step(step_b), .TC(tc_b), .All_done(ad_b)
`ifdef SIEVE_STRIDE_WRAPS_EN
        , .Wraps(wr_b)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_ready(input int k);
        if (Clear || int'(Load_ch) >= 4) return 0;
        return (m_st[k][int'(Load_ch)] != 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_st[k][i] = 0; m_cnt[k][i] = 0; m_base[k][i] = 0;
                m_str[k][i] = 0; m_wr[k][i] = 0; m_step[k][i] = 0;
            end
    endtask

    task automatic model_update();
        int r [2];
        int nx;
        for (int k = 0; k < 2; k++) r[k] = m_ready(k);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_step[k][i] = 0;
                if (Clear) begin
                    m_st[k][i] = 0; m_cnt[k][i] = 0; m_base[k][i] = 0;
                    m_str[k][i] = 0; m_wr[k][i] = 0;
                end else if (Load_valid && r[k] == 1 && int'(Load_ch) == i) begin
                    m_cnt[k][i] = int'(Load_base);
                    m_wr[k][i]  = 0;
                    if (int'(Load_base) > lim[k] - 1 || Load_stride == 0) begin
                        m_st[k][i] = 2;
                    end else begin
                        m_st[k][i]   = 1;
                        m_base[k][i] = int'(Load_base);
                        m_str[k][i]  = int'(Load_stride);
                        m_step[k][i] = 1;
                    end
                end else if (m_st[k][i] == 1 && En[i]) begin
                    nx = m_cnt[k][i] + m_str[k][i];
                    if (nx <= lim[k] - 1) begin
                        m_cnt[k][i]  = nx;
                        m_step[k][i] = 1;
                    end else if (rol[k] == 0) begin
                        m_st[k][i] = 2;
                    end else begin
                        m_cnt[k][i]  = m_base[k][i];
                        m_step[k][i] = 1;
                        if (m_wr[k][i] < 255) m_wr[k][i]++;
                    end
                end
            end
    endtask

    task automatic check_all();
        logic [31:0] cv;
        logic [3:0]  sv, tv;
        int alld;
        string p;
        for (int k = 0; k < 2; k++) begin
            p    = (k == 0) ? "a" : "b";
            cv   = (k == 0) ? cnt_a : cnt_b;
            sv   = (k == 0) ? step_a : step_b;
            tv   = (k == 0) ? tc_a : tc_b;
            alld = 1;
            for (int i = 0; i < 4; i++) begin
                if (m_st[k][i] == 1) alld = 0;
                chk($sformatf("%s.count%0d", p, i), int'(cv[i*8 +: 8]), m_cnt[k][i]);
                chk($sformatf("%s.step%0d", p, i), int'(sv[i]), m_step[k][i]);
                chk($sformatf("%s.tc%0d", p, i), int'(tv[i]), (m_st[k][i] == 2) ? 1 : 0);
`ifdef SIEVE_STRIDE_WRAPS_EN
                chk($sformatf("%s.wraps%0d", p, i),
                    int'((k == 0) ? wr_a[i*8 +: 8] : wr_b[i*8 +: 8]), m_wr[k][i]);
`endif
            end
            chk($sformatf("%s.all_done", p), int'((k == 0) ? ad_a : ad_b), alld);
            chk($sformatf("%s.load_ready", p), int'((k == 0) ? rdy_a : rdy_b), m_ready(k));
        end
    endtask

    task automatic cycle();
        @(negedge Clock);
        check_all();
        model_update();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        @(negedge Clock);
        check_all();
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic load(input int ch, input int base, input int stride);
        Load_valid  = 1'b1;
        Load_ch     = 2'(ch);
        Load_base   = 8'(base);
        Load_stride = 6'(stride);
        cycle();
        Load_valid  = 1'b0;
    endtask

    initial begin
        int exp_b [4] = '{2, 6, 2, 6};
        model_reset();
        #2;
        do_reset();

        // Stop at limit on a, immediate DONE on b (base above its limit).
        En = 4'b0001;
        load(0, 200, 20);
        repeat (4) cycle();
        chk("a.limit_count", int'(cnt_a[7:0]), 240);
        chk("a.limit_tc", int'(tc_a[0]), 1);
        chk("b.bigbase_tc", int'(tc_b[0]), 1);

        // Rollover on b: 2,6,2,6.
        En = 4'b0010;
        load(1, 2, 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("b.roll%0d", j), int'(cnt_b[15:8]), exp_b[j]);
            chk($sformatf("b.roll_tc%0d", j), int'(tc_b[1]), 0);
            cycle();
        end

        // Enable gating on ch2, then a load to a running channel and a zero stride.
        En = 4'b0110;
        load(2, 3, 3);
        En = 4'b0010; cycle(); cycle();
        En = 4'b0110; cycle();
        load(1, 1, 1);
        load(3, 5, 0);
        chk("a.zero_stride_step", int'(step_a[3]), 0);
        chk("a.zero_stride_tc", int'(tc_a[3]), 1);

        // Clear with a same-cycle load, then reset mid-run.
        Clear = 1'b1;
        load(0, 4, 1);
        Clear = 1'b0;
        load(0, 1, 1);
        En = 4'b1111;
        cycle();
        do_reset();
        cycle();

        // Overshoot past 8-bit width must not wrap.
        load(0, 250, 10);
        cycle(); cycle();
        chk("a.no_wrap_count", int'(cnt_a[7:0]), 250);
        chk("a.no_wrap_tc", int'(tc_a[0]), 1);

        for (int n = 0; n < 600; n++) begin
            Clear       = ($urandom_range(0, 39) == 0);
            Load_valid  = ($urandom_range(0, 2) == 0);
            Load_ch     = 2'($urandom_range(0, 3));
            Load_base   = $urandom_range(0, 1) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
            Load_stride = $urandom_range(0, 3) != 0 ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            En          = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end
        Clear = 1'b0;
        Load_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
